rv0_ifu: RTL and testbench

RV0_IFU -- requirements
Module: rv0_ifu

---
 rtl/rv0_ifu.sv | 222 ++++++++++++++++++++++
 tb/tb_rv0_ifu.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv0_ifu.sv
// -----------------------------------------------------------------------------
// rv0_ifu -- instruction fetch unit for a small RV32 core.
//
// Fetches one 32-bit word at a time over an AHB-Lite master port (single,
// non-burst, read-only transfers) and buffers the results in a 2-entry FIFO
// that feeds decode.
//
// Ports
//   clk, rst        : single rising-edge clock, synchronous active-high reset
//   haddr, htrans   : AHB address / transfer type (IDLE or NONSEQ only)
//   hsize, hburst,
//   hwrite          : constant WORD / SINGLE / read
//   hrdata, hready,
//   hresp           : AHB read data, transfer done, OKAY/ERROR
//   redirect_req,
//   redirect_pc     : branch/jump/trap redirect; flushes and restarts fetch
//   insn_valid,
//   insn_ready      : decode handshake
//   insn, insn_pc,
//   insn_fault      : FIFO head, qualified by insn_valid
//   dbg_state       : current FSM state (IDLE=0, ADDR=1, DATA=2, HALT=3)
//
// Decode handshake: insn_valid/insn/insn_pc/insn_fault are driven straight
// from registers. An entry transfers (pops) on every rising edge where
// insn_valid && insn_ready; while insn_valid is high and insn_ready is low the
// head entry is held stable. insn_valid never depends on insn_ready.
//
// Only XLEN = 32 is supported.
// -----------------------------------------------------------------------------
module rv0_ifu #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] PC_RST_VAL = 'h0010_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] haddr,
  output logic [1:0]      htrans,
  output logic [2:0]      hsize,
  output logic [2:0]      hburst,
  output logic            hwrite,
  input  logic [31:0]     hrdata,
  input  logic            hready,
  input  logic            hresp,
  input  logic            redirect_req,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [31:0]     insn,
  output logic [XLEN-1:0] insn_pc,
  output logic            insn_fault,
  output logic [1:0]      dbg_state
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    HALT = 2'd3
  } state_e;

  state_e          state_q, state_d;
  // Next address to fetch.
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  // Address of the transfer currently in its address or data phase. Kept
  // separate from fetch_pc so a redirect can retarget fetch_pc while haddr
  // is held for a stalled address phase.
  logic [XLEN-1:0] addr_pc_q, addr_pc_d;
  // The in-flight transfer was overtaken by a redirect; its result is dropped.
  logic            kill_q, kill_d;

  logic [1:0][31:0]     ent_insn_q, ent_insn_d;
  logic [1:0][XLEN-1:0] ent_pc_q, ent_pc_d;
  logic [1:0]           ent_fault_q, ent_fault_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [1:0]           count_q, count_d;

  logic        pop;
  logic        push;
  logic [31:0] push_insn;
  logic        push_fault;
  logic        data_done;
  logic        kill_now;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_pc_d   = addr_pc_q;
    kill_d      = kill_q;
    ent_insn_d  = ent_insn_q;
    ent_pc_d    = ent_pc_q;
    ent_fault_d = ent_fault_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    push_insn   = '0;
    push_fault  = 1'b0;
    push        = 1'b0;

    pop       = (count_q != 2'd0) && insn_ready;
    data_done = (state_q == DATA) && hready;
    // A redirect arriving in the completing cycle kills the result too.
    kill_now  = kill_q || redirect_req;

    // Fetches are only launched with room reserved, so the fullness guard
    // only keeps the pointers coherent.
    if (data_done && !kill_now && ((count_q != 2'd2) || pop)) begin
      push       = 1'b1;
      push_fault = hresp;
      push_insn  = hresp ? 32'h0 : hrdata;
    end

    // FIFO: a redirect flushes everything, including a same-cycle push/pop.
    if (redirect_req) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push) begin
        ent_insn_d[wr_ptr_q]  = push_insn;
        ent_pc_d[wr_ptr_q]    = addr_pc_q;
        ent_fault_d[wr_ptr_q] = push_fault;
        wr_ptr_d              = ~wr_ptr_q;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    case (state_q)
      IDLE: begin
        if (count_q < 2'd2) begin
          state_d = ADDR;
        end
      end
      ADDR: begin
        kill_d = kill_now;
        if (hready) begin
          state_d = DATA;
          // A killed fetch does not advance; fetch_pc already holds (or is
          // about to take) the redirect target.
          if (!kill_now) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
          end
        end
      end
      DATA: begin
        kill_d = kill_now;
        if (hready) begin
          kill_d = 1'b0;
          if (push && push_fault) begin
            state_d = HALT;
          end else if (count_d < 2'd2) begin
            state_d = ADDR;
          end else begin
            state_d = IDLE;
          end
        end
      end
      HALT: begin
        if (redirect_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect_req) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
    end

    // Latch the address only when an address phase begins; it is then held
    // for as long as hready stays low.
    if ((state_d == ADDR) && (state_q != ADDR)) begin
      addr_pc_d = fetch_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= PC_RST_VAL;
      addr_pc_q   <= PC_RST_VAL;
      kill_q      <= 1'b0;
      ent_insn_q  <= '0;
      ent_pc_q    <= '0;
      ent_fault_q <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      addr_pc_q   <= addr_pc_d;
      kill_q      <= kill_d;
      ent_insn_q  <= ent_insn_d;
      ent_pc_q    <= ent_pc_d;
      ent_fault_q <= ent_fault_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign haddr      = addr_pc_q;
  assign htrans     = (state_q == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign hsize      = HSIZE_WORD;
  assign hburst     = HBURST_SINGLE;
  assign hwrite     = 1'b0;
  assign insn_valid = (count_q != 2'd0);
  assign insn       = ent_insn_q[rd_ptr_q];
  assign insn_pc    = ent_pc_q[rd_ptr_q];
  assign insn_fault = ent_fault_q[rd_ptr_q];
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_rv0_ifu.sv
// -----------------------------------------------------------------------------
// tb_rv0_ifu -- self-checking bench for rv0_ifu.
//
// The bench plays the AHB slave and the decode stage. A transaction-level
// model tracks the expected instruction stream: the sequence of fetch
// addresses (start PC, +4 per completed live fetch, restart at a redirect),
// which transfers a redirect kills, and the expected decode queue exp_q.
// Every cycle the DUT outputs are compared to the model; directed scenarios
// add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_rv0_ifu;

  localparam logic [31:0] PC_RST = 32'h0010_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        redirect_req;
  logic [31:0] redirect_pc;
  logic        insn_valid;
  logic        insn_ready;
  logic [31:0] insn;
  logic [31:0] insn_pc;
  logic        insn_fault;
  logic [1:0]  dbg_state;

  // clock / reset
  always #5 clk = ~clk;

  rv0_ifu #(.XLEN(32), .PC_RST_VAL(PC_RST)) dut (
    .clk          (clk),
    .rst          (rst),
    .haddr        (haddr),
    .htrans       (htrans),
    .hsize        (hsize),
    .hburst       (hburst),
    .hwrite       (hwrite),
    .hrdata       (hrdata),
    .hready       (hready),
    .hresp        (hresp),
    .redirect_req (redirect_req),
    .redirect_pc  (redirect_pc),
    .insn_valid   (insn_valid),
    .insn_ready   (insn_ready),
    .insn         (insn),
    .insn_pc      (insn_pc),
    .insn_fault   (insn_fault),
    .dbg_state    (dbg_state)
  );

  // scoreboard: {fault, pc, data}
  logic [64:0] exp_q[$];

  bit          m_rst_applied = 1'b1;
  bit          m_dphase;
  bit          m_dkill;
  bit          m_akill;
  bit          m_halted;
  bit          m_prev_wait;
  logic [31:0] m_dpc;
  logic [31:0] m_fetch = PC_RST;
  logic [31:0] m_prev_haddr;
  int          idle_run;

  int n_vec;
  int n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_outputs();
    logic [64:0] e;
    chk("bus_ties", {25'h0, hsize, hburst, hwrite}, {25'h0, 3'b010, 3'b000, 1'b0});
    if (m_rst_applied) begin
      chk("rst_htrans", htrans, 2'b00);
      chk("rst_haddr", haddr, PC_RST);
      chk("rst_valid", insn_valid, 1'b0);
      chk("rst_insn", insn, 32'h0);
      chk("rst_insn_pc", insn_pc, 32'h0);
      chk("rst_fault", insn_fault, 1'b0);
    end else begin
      chk("insn_valid", insn_valid, exp_q.size() != 0);
      if (exp_q.size() != 0) begin
        e = exp_q[0];
        chk("insn", insn, e[31:0]);
        chk("insn_pc", insn_pc, e[63:32]);
        chk("insn_fault", insn_fault, e[64]);
      end
      chk("htrans_legal", (htrans == 2'b00) || (htrans == 2'b10), 1'b1);
      if (m_prev_wait) begin
        chk("hold_htrans", htrans, 2'b10);
        chk("hold_haddr", haddr, m_prev_haddr);
      end else if (htrans == 2'b10) begin
        chk("fetch_addr", haddr, m_fetch);
        chk("fetch_while_halted", m_halted, 1'b0);
        chk("fetch_without_space", (exp_q.size() < 2) && !m_dphase, 1'b1);
      end
      if ((htrans == 2'b00) && !m_dphase && !m_halted && (exp_q.size() < 2)) begin
        idle_run++;
      end else begin
        idle_run = 0;
      end
      chk("idle_with_space", idle_run <= 2, 1'b1);
    end
  endtask

  // Advance the model across the coming rising edge, given the inputs just
  // driven and the bus request the DUT is presenting.
  task automatic model_update();
    bit pop;
    bit redir;
    bit aphase;
    bit kill;
    m_rst_applied = rst;
    if (rst) begin
      exp_q.delete();
      m_dphase    = 1'b0;
      m_dkill     = 1'b0;
      m_akill     = 1'b0;
      m_halted    = 1'b0;
      m_prev_wait = 1'b0;
      m_fetch     = PC_RST;
      idle_run    = 0;
      return;
    end
    pop    = (exp_q.size() != 0) && insn_ready;
    redir  = redirect_req;
    aphase = (htrans == 2'b10);
    if (redir) exp_q.delete();
    else if (pop) void'(exp_q.pop_front());
    if (m_dphase && hready) begin
      if (!m_dkill && !redir) begin
        exp_q.push_back({hresp, m_dpc, hresp ? 32'h0 : hrdata});
        if (hresp) m_halted = 1'b1;
      end
      m_dphase = 1'b0;
    end else if (m_dphase && redir) begin
      m_dkill = 1'b1;
    end
    if (aphase) begin
      kill = m_akill || redir;
      if (hready) begin
        m_dphase = 1'b1;
        m_dpc    = haddr;
        m_dkill  = kill;
        m_akill  = 1'b0;
        if (!kill) m_fetch = m_fetch + 32'd4;
      end else begin
        m_akill = kill;
      end
    end
    if (redir) begin
      m_fetch  = redirect_pc & ~32'h3;
      m_halted = 1'b0;
    end
    m_prev_wait  = aphase && !hready;
    m_prev_haddr = haddr;
  endtask

  // driver: check the state reached so far, then drive inputs for the next edge
  task automatic step(input logic i_rst, input logic i_hready, input logic i_hresp,
                      input logic i_redir, input logic [31:0] i_rpc, input logic i_ready);
    @(negedge clk);
    compare_outputs();
    rst          = i_rst;
    hready       = i_hready;
    hresp        = i_hresp;
    hrdata       = $urandom();
    redirect_req = i_redir;
    redirect_pc  = i_rpc;
    insn_ready   = i_ready;
    model_update();
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    int          ns;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] fpc;
    bit          found;
    rst          = 1'b1;
    hready       = 1'b1;
    hresp        = 1'b0;
    hrdata       = 32'h0;
    redirect_req = 1'b0;
    redirect_pc  = 32'h0;
    insn_ready   = 1'b0;
    n_vec        = 0;
    n_fail       = 0;

    // First fetch timing out of reset.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("r029_rst_htrans", htrans, 2'b00);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("r029_nonseq", htrans, 2'b10);
    chk("r029_haddr", haddr, 32'h0010_0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("r029_not_yet_valid", insn_valid, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("r029_valid", insn_valid, 1'b1);
    chk("r029_insn_pc", insn_pc, 32'h0010_0000);
    chk("r029_next_haddr", haddr, 32'h0010_0004);
    chk("r029_next_nonseq", htrans, 2'b10);

    // Back-pressure: exactly two words buffered, then one refill per pop.
    do_reset();
    ns = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (htrans == 2'b10) ns++;
    end
    chk("r030_fetch_count", ns, 2);
    chk("r030_htrans_idle", htrans, 2'b00);
    chk("r030_head_pc", insn_pc, 32'h0010_0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    ns = 0;
    a0 = 32'hdead_beef;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      if (htrans == 2'b10) begin
        if (ns == 0) a0 = haddr;
        ns++;
      end
    end
    chk("r030_refill_count", ns, 1);
    chk("r030_refill_addr", a0, 32'h0010_0008);
    chk("r030_head_after_pop", insn_pc, 32'h0010_0004);

    // Redirect during a stalled data phase.
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    chk("r031_stalled_idle", htrans, 2'b00);
    a0 = 32'hdead_beef;
    a1 = 32'hdead_beef;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if ((htrans == 2'b10) && (a0 == 32'hdead_beef)) a0 = haddr;
      if (insn_valid && (a1 == 32'hdead_beef)) a1 = insn_pc;
    end
    chk("r031_next_fetch", a0, 32'h0000_0200);
    chk("r031_first_pc", a1, 32'h0000_0200);

    // Bus error halts fetch until a redirect.
    do_reset();
    found = 1'b0;
    fpc   = 32'hdead_beef;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b0, 1'b1, m_dphase && (m_dpc == 32'h0010_0004), 1'b0, 32'h0, 1'b1);
      if (insn_valid && insn_fault) begin
        found = 1'b1;
        fpc   = insn_pc;
        chk("r032_fault_insn", insn, 32'h0);
      end
    end
    chk("r032_fault_seen", found, 1'b1);
    chk("r032_fault_pc", fpc, 32'h0010_0004);
    ns = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if (htrans == 2'b10) ns++;
    end
    chk("r032_halted_fetches", ns, 0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0, 1'b1);
    a0 = 32'hdead_beef;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if ((htrans == 2'b10) && (a0 == 32'hdead_beef)) a0 = haddr;
    end
    chk("r032_resume_addr", a0, 32'h0);

    // Fetch address wraps past the top of memory.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    ns = 0;
    a0 = 32'hdead_beef;
    a1 = 32'hdead_beef;
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      if (htrans == 2'b10) begin
        if (ns == 0) a0 = haddr;
        if (ns == 1) a1 = haddr;
        ns++;
      end
    end
    chk("r033_first", a0, 32'hFFFF_FFFC);
    chk("r033_wrap", a1, 32'h0000_0000);

    // Redirect and pop together on a full FIFO.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("r034_full_valid", insn_valid, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_4000, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk("r034_flushed", insn_valid, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 14) == 0,
           rpc,
           (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0));
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
